// File: rtl/note_input_pkg.sv
`default_nettype none
// ============================================================================
// Module      : note_input_pkg
// Description : Shared constants, press-FSM state encoding and a small helper
//               for the note_input_capture front end.
// Contents    : NUM_KEYS, BOARD_DEBOUNCE_CYCLES, press_state_t, more_than_one()
// Revision    : 1.0 - initial release
// ============================================================================
package note_input_pkg;

  localparam int NUM_KEYS              = 4;
  // 10 ms at 50 MHz; the simulation default of 4 is set on the modules.
  localparam int BOARD_DEBOUNCE_CYCLES = 500000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    HOLD  = 2'd1,
    BLOCK = 2'd2
  } press_state_t;

  // True when more than one bit is set: clearing the lowest set bit
  // leaves something behind only if a second bit was present.
  function automatic logic more_than_one(input logic [NUM_KEYS-1:0] v);
    return (v & (v - 1'b1)) != '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/note_input_capture_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : key_debouncer
// Description : Two-flop synchroniser, polarity normalisation and whole-vector
//               debounce of the board keys. Output is 1 = pressed.
// Ports       : clk, reset     - clock, synchronous active-high reset
//               key_raw[3:0]   - raw asynchronous key pins
//               keys_level[3:0]- debounced, normalised key level
// Revision    : 1.0 - initial release
// ============================================================================
module key_debouncer
  import note_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  output logic [NUM_KEYS-1:0] keys_level
);

  // Raw pin value that normalises to "all released".
  localparam logic [NUM_KEYS-1:0] C_RAW_RELEASED = {NUM_KEYS{ACTIVE_LOW != 0}};
  localparam logic [CNT_W-1:0]    C_CNT_LAST     = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] r_s_prev;
  logic [NUM_KEYS-1:0] r_level;
  logic [CNT_W-1:0]    r_cnt;
  logic [NUM_KEYS-1:0] w_s;

  assign w_s        = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;
  assign keys_level = r_level;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1  <= C_RAW_RELEASED;
      r_sync2  <= C_RAW_RELEASED;
      r_s_prev <= '0;
      r_level  <= '0;
      r_cnt    <= '0;
    end else begin
      r_sync1  <= key_raw;
      r_sync2  <= r_sync1;
      r_s_prev <= w_s;
      // Any movement restarts the stability window; the counter only runs
      // while the synchronised vector is steady and differs from the level.
      if (w_s != r_s_prev) begin
        r_cnt <= '0;
      end else if (w_s != r_level) begin
        if (r_cnt == C_CNT_LAST) begin
          r_level <= w_s;
          r_cnt   <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end else begin
        r_cnt <= '0;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/note_input_capture.sv
`default_nettype none
// ============================================================================
// Module      : note_input_capture
// Description : Key front end: debounced level path plus a press FSM that
//               delivers one note per physical press over valid/ack.
// Ports       : clk, reset       - clock, synchronous active-high reset
//               key_raw[3:0]     - raw key pins
//               enable           - presses while low are discarded
//               note_ack         - consumer took the pending note
//               note_valid       - a captured note is pending
//               note_value[3:0]  - captured key vector (1 = pressed)
//               multi_key        - more than one key down at capture
//               overrun          - sticky: a press was dropped (note unacked)
//               keys_level[3:0]  - debounced key level
// Revision    : 1.0 - initial release
// ============================================================================
module note_input_capture
  import note_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W           = 20,
  parameter int ACTIVE_LOW      = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_raw,
  input  logic                enable,
  input  logic                note_ack,
  output logic                note_valid,
  output logic [NUM_KEYS-1:0] note_value,
  output logic                multi_key,
  output logic                overrun,
  output logic [NUM_KEYS-1:0] keys_level
);

  logic [NUM_KEYS-1:0] w_level;
  press_state_t        r_state;
  press_state_t        w_state_next;
  logic                w_capture;

  key_debouncer #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W),
    .ACTIVE_LOW      (ACTIVE_LOW)
  ) u_debouncer (
    .clk        (clk),
    .reset      (reset),
    .key_raw    (key_raw),
    .keys_level (w_level)
  );

  assign keys_level = w_level;

  // HOLD and BLOCK both swallow everything until a full release; BLOCK just
  // records that the press started while responses were not accepted.
  always_comb begin
    w_state_next = r_state;
    w_capture    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_level != '0) begin
          if (enable) begin
            w_capture    = 1'b1;
            w_state_next = HOLD;
          end else begin
            w_state_next = BLOCK;
          end
        end
      end
      HOLD, BLOCK: begin
        if (w_level == '0) begin
          w_state_next = IDLE;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      note_valid <= 1'b0;
      note_value <= '0;
      multi_key  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      r_state <= w_state_next;
      // A capture may replace the pending note only if that note is being
      // acknowledged in the same cycle; otherwise the press is dropped.
      if (w_capture && (!note_valid || note_ack)) begin
        note_valid <= 1'b1;
        note_value <= w_level;
        multi_key  <= more_than_one(w_level);
      end else begin
        if (w_capture) begin
          overrun <= 1'b1;
        end
        if (note_valid && note_ack) begin
          note_valid <= 1'b0;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_note_input_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_note_input_capture
// Description : Self-checking bench for note_input_capture. A press-event
//               model runs alongside the DUT and is compared every cycle;
//               literal expectations pin the key scenarios.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_note_input_capture;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] key_raw;
  logic       enable;
  logic       note_ack;
  logic       note_valid;
  logic [3:0] note_value;
  logic       multi_key;
  logic       overrun;
  logic [3:0] keys_level;

  always #5 clk = ~clk;

  note_input_capture #(
    .DEBOUNCE_CYCLES (D),
    .CNT_W           (20),
    .ACTIVE_LOW      (1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_raw    (key_raw),
    .enable     (enable),
    .note_ack   (note_ack),
    .note_valid (note_valid),
    .note_value (note_value),
    .multi_key  (multi_key),
    .overrun    (overrun),
    .keys_level (keys_level)
  );

  int checks = 0;
  int errors = 0;
  int rises  = 0;

  task automatic check(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // s     : pressed-key vector seen two clocks after the pins
  // level : follows s once s has held one value for D+1 cycles
  // event : level leaves zero (only the first nonzero level after a full
  //         release counts); it becomes a note if enable is high then.
  logic [3:0] m_q1, m_s, m_level, m_value;
  int         m_run;
  bit         m_was_zero, m_valid, m_multi, m_over;
  bit         m_ready = 1'b0;

  always @(posedge clk) begin : model
    logic [3:0] lvl_old;
    bit         cap;
    if (reset) begin
      m_q1 = 4'h0; m_s = 4'h0; m_run = 1; m_level = 4'h0;
      m_was_zero = 1'b1; m_valid = 1'b0; m_value = 4'h0;
      m_multi = 1'b0; m_over = 1'b0; m_ready = 1'b1;
    end else if (m_ready) begin
      lvl_old = m_level;
      if (m_run >= D + 1 && m_s != m_level) m_level = m_s;
      cap = m_was_zero && (lvl_old != 4'h0) && enable;
      m_was_zero = (lvl_old == 4'h0);
      if (cap && (!m_valid || note_ack)) begin
        m_valid = 1'b1;
        m_value = lvl_old;
        m_multi = ($countones(lvl_old) > 1);
      end else begin
        if (cap) m_over = 1'b1;
        if (m_valid && note_ack) m_valid = 1'b0;
      end
      if (m_q1 == m_s) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_run = 1;
      end
      m_s  = m_q1;
      m_q1 = ~key_raw;
    end
  end

  // ---------------- per-cycle comparison ----------------
  bit prev_valid = 1'b0;
  always @(negedge clk) begin
    if (m_ready) begin
      check("keys_level", keys_level, m_level);
      check("note_valid", {3'b0, note_valid}, {3'b0, m_valid});
      check("overrun", {3'b0, overrun}, {3'b0, m_over});
      if (m_valid) begin
        check("note_value", note_value, m_value);
        check("multi_key", {3'b0, multi_key}, {3'b0, m_multi});
      end
      if (note_valid === 1'b1 && !prev_valid) rises++;
      prev_valid = (note_valid === 1'b1);
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic ack_once();
    note_ack = 1'b1;
    step(1);
    note_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; key_raw = 4'hF; enable = 1'b0; note_ack = 1'b0;
    step(3);
    reset = 1'b0;

    // Idle keys: nothing happens.
    step(50);
    check("idle_valid", {3'b0, note_valid}, 4'h0);
    check("idle_level", keys_level, 4'h0);
    check("idle_overrun", {3'b0, overrun}, 4'h0);
    check("idle_rises", 4'(rises), 4'd0);

    // Single key press, held, released, then acked.
    enable = 1'b1;
    key_raw = 4'b1101;
    step(6);
    check("single_level_early", keys_level, 4'h0);
    step(1);
    check("single_level", keys_level, 4'b0010);
    check("single_valid_early", {3'b0, note_valid}, 4'h0);
    step(1);
    check("single_valid", {3'b0, note_valid}, 4'h1);
    step(12);
    check("single_value", note_value, 4'b0010);
    check("single_multi", {3'b0, multi_key}, 4'h0);
    key_raw = 4'hF;
    step(15);
    check("single_hold_valid", {3'b0, note_valid}, 4'h1);
    ack_once();
    check("single_acked", {3'b0, note_valid}, 4'h0);
    step(20);
    check("single_rises", 4'(rises), 4'd1);

    // Bouncing KEY0, then settles pressed.
    for (int i = 0; i < 6; i++) begin
      key_raw = (i % 2 == 0) ? 4'b1110 : 4'b1111;
      step(2);
    end
    check("bounce_level", keys_level, 4'h0);
    key_raw = 4'b1110;
    step(15);
    check("bounce_value", note_value, 4'b0001);
    check("bounce_rises", 4'(rises), 4'd2);
    ack_once();
    key_raw = 4'hF;
    step(15);

    // Chord of KEY3+KEY0, then KEY1 joins during the hold.
    key_raw = 4'b0110;
    step(12);
    check("chord_value", note_value, 4'b1001);
    check("chord_multi", {3'b0, multi_key}, 4'h1);
    key_raw = 4'b0100;
    step(12);
    check("chord_level", keys_level, 4'b1011);
    check("chord_value_kept", note_value, 4'b1001);
    check("chord_rises", 4'(rises), 4'd3);
    check("chord_overrun", {3'b0, overrun}, 4'h0);
    ack_once();
    key_raw = 4'hF;
    step(15);

    // Press while disabled, enable rises mid-hold: no note.
    enable = 1'b0;
    key_raw = 4'b1011;
    step(12);
    enable = 1'b1;
    step(10);
    check("blocked_valid", {3'b0, note_valid}, 4'h0);
    key_raw = 4'hF;
    step(12);
    check("blocked_release_valid", {3'b0, note_valid}, 4'h0);
    key_raw = 4'b1011;
    step(12);
    check("repress_value", note_value, 4'b0100);
    check("repress_rises", 4'(rises), 4'd4);
    key_raw = 4'hF;
    step(12);
    // Second press without ack: dropped, overrun set.
    key_raw = 4'b0111;
    step(12);
    check("overrun_set", {3'b0, overrun}, 4'h1);
    check("overrun_value", note_value, 4'b0100);
    key_raw = 4'hF;
    step(12);
    // Ack lands on the capture cycle: the new note wins.
    key_raw = 4'b1110;
    step(7);
    note_ack = 1'b1;
    step(1);
    note_ack = 1'b0;
    check("ackcap_valid", {3'b0, note_valid}, 4'h1);
    check("ackcap_value", note_value, 4'b0001);
    check("ackcap_overrun", {3'b0, overrun}, 4'h1);
    step(5);

    // Reset with a pending note and a key held; release during reset.
    reset = 1'b1;
    step(1);
    check("rst_valid", {3'b0, note_valid}, 4'h0);
    check("rst_value", note_value, 4'h0);
    check("rst_overrun", {3'b0, overrun}, 4'h0);
    check("rst_level", keys_level, 4'h0);
    key_raw = 4'hF;
    step(2);
    reset = 1'b0;
    step(20);
    check("post_rst_valid", {3'b0, note_valid}, 4'h0);
    check("final_rises", 4'(rises), 4'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
